// File: rtl/ss_pkg.sv
// rtl/ss_pkg.sv - shared constants and types for the seven-segment display blocks
//
// Purpose: hex-to-segment lookup table (active-low abcdefg, bit 6 = a),
//          blank/none patterns and the digit index type.
package ss_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] SEL_NONE  = 4'hF;

  // Entry n is the active-low pattern for hex digit n (entry 15 listed first).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
    7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };

  typedef logic [1:0] digit_t;

endpackage

// File: rtl/ss_hex_decode.sv
// rtl/ss_hex_decode.sv - combinational hex nibble to active-low segment decoder
//
// Ports:
//   nibble  in  4 : hex digit 0..F
//   seg     out 7 : active-low abcdefg pattern, bit 6 = a, bit 0 = g
import ss_pkg::*;

module ss_hex_decode (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/ss_scan_driver.sv
// rtl/ss_scan_driver.sv - 4-digit multiplexed seven-segment driver with double buffering, blanking and PWM
//
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   load              : one-cycle strobe capturing value/dp_in into the shadow buffer
//   value[15:0]       : four hex nibbles, [3:0] = digit 0 (rightmost)
//   dp_in[3:0]        : decimal point per digit, 1 = lit
//   blank_lz          : leading-zero blanking enable
//   brightness[2:0]   : 0 = 1/8 on-time .. 7 = full on
//   pending           : shadow holds data not yet displayed
//   frame_start       : pulse one cycle before outputs show digit 0
//   ss_abcdefg_l[6:0] : segments, active-low
//   ss_dp_l           : decimal point, active-low
//   ss_sel_l[3:0]     : digit enables, active-low
import ss_pkg::*;

module ss_scan_driver #(
  parameter int DIGIT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  input  logic [2:0]  brightness,
  output logic        pending,
  output logic        frame_start,
  output logic [6:0]  ss_abcdefg_l,
  output logic        ss_dp_l,
  output logic [3:0]  ss_sel_l
);

  localparam int SUB   = DIGIT_CYCLES / 8;
  localparam int SUB_W = (SUB > 1) ? $clog2(SUB) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB - 1);

  // The per-digit tick is kept as {slot, sub_cnt} so the PWM subslot index
  // falls out directly without dividing by DIGIT_CYCLES/8.
  logic [SUB_W-1:0] sub_cnt;
  logic [2:0]       slot;
  digit_t           digit;

  logic [15:0] shadow_value, active_value;
  logic [3:0]  shadow_dp, active_dp;

  logic       tick_wrap, frame_end;
  logic [3:0] nibble;
  logic [6:0] dec_seg;
  logic [3:0] lz_all;
  logic       blank;

  assign tick_wrap = (slot == 3'd7) && (sub_cnt == SUB_LAST);
  assign frame_end = tick_wrap && (digit == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_cnt <= '0;
      slot    <= '0;
      digit   <= '0;
    end else if (sub_cnt == SUB_LAST) begin
      sub_cnt <= '0;
      slot    <= slot + 3'd1;
      if (slot == 3'd7) digit <= digit + 2'd1;
    end else begin
      sub_cnt <= sub_cnt + SUB_W'(1);
    end
  end

  // A load landing on the frame boundary bypasses the shadow wait and goes
  // live immediately, so pending never rises for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_value <= '0;
      shadow_dp    <= '0;
      active_value <= '0;
      active_dp    <= '0;
      pending      <= 1'b0;
    end else begin
      if (load) begin
        shadow_value <= value;
        shadow_dp    <= dp_in;
      end
      if (frame_end) begin
        pending <= 1'b0;
        if (load) begin
          active_value <= value;
          active_dp    <= dp_in;
        end else if (pending) begin
          active_value <= shadow_value;
          active_dp    <= shadow_dp;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  assign nibble = active_value[{digit, 2'b00} +: 4];

  ss_hex_decode u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  // lz_all[i]: nibble i and every nibble above it are zero; digit 0 never blanks.
  always_comb begin
    lz_all    = '0;
    lz_all[3] = (active_value[15:12] == 4'h0);
    lz_all[2] = lz_all[3] && (active_value[11:8] == 4'h0);
    lz_all[1] = lz_all[2] && (active_value[7:4] == 4'h0);
    blank     = blank_lz && lz_all[digit];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_abcdefg_l <= SEG_BLANK;
      ss_dp_l      <= 1'b1;
      ss_sel_l     <= SEL_NONE;
      frame_start  <= 1'b0;
    end else begin
      ss_abcdefg_l <= blank ? SEG_BLANK : dec_seg;
      ss_dp_l      <= ~active_dp[digit];
      ss_sel_l     <= (slot <= brightness) ? ~(4'b0001 << digit) : SEL_NONE;
      frame_start  <= frame_end;
    end
  end

endmodule

// File: tb/tb_ss_scan_driver.sv
// tb/tb_ss_scan_driver.sv - directed self-checking bench for ss_scan_driver
module tb_ss_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [2:0]  brightness;
  logic        pending, frame_start, ss_dp_l;
  logic [6:0]  ss_abcdefg_l;
  logic [3:0]  ss_sel_l;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ss_scan_driver #(.DIGIT_CYCLES(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .value        (value),
    .dp_in        (dp_in),
    .blank_lz     (blank_lz),
    .brightness   (brightness),
    .pending      (pending),
    .frame_start  (frame_start),
    .ss_abcdefg_l (ss_abcdefg_l),
    .ss_dp_l      (ss_dp_l),
    .ss_sel_l     (ss_sel_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    value   = v;
    dp_in   = dp;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  // Returns at the negedge where frame_start is high (counters at frame cycle 0).
  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 200);
    chk("frame_start_seen", frame_start, 1'b1);
  endtask

  // Must be entered with counters at frame cycle 0; checks one full 64-cycle frame.
  task automatic scan_frame(input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3,
                            input logic [3:0] dpm, input int bright);
    logic [6:0] es [4];
    int lit;
    es  = '{e0, e1, e2, e3};
    lit = 0;
    for (int k = 0; k < 64; k++) begin
      int d, s;
      logic [3:0] esel;
      logic edp, efs;
      @(negedge clk);
      d    = k / 16;
      s    = (k % 16) / 2;
      esel = (s <= bright) ? ~(4'b0001 << d) : 4'hF;
      edp  = ~dpm[d];
      efs  = (k == 63);
      if (ss_sel_l != 4'hF) lit++;
      chk("scan_sel", ss_sel_l, esel);
      chk("scan_seg", ss_abcdefg_l, es[d]);
      chk("scan_dp", ss_dp_l, edp);
      chk("scan_frame_start", frame_start, efs);
    end
    chk("pwm_lit_cycles", lit, 8 * (bright + 1));
  endtask

  initial begin
    rst_n      = 1'b0;
    load       = 1'b0;
    value      = '0;
    dp_in      = '0;
    blank_lz   = 1'b0;
    brightness = 3'd7;

    // Reset state
    step(3);
    chk("rst_sel", ss_sel_l, 4'hF);
    chk("rst_seg", ss_abcdefg_l, 7'h7F);
    chk("rst_dp", ss_dp_l, 1'b1);
    chk("rst_pending", pending, 1'b0);
    chk("rst_frame_start", frame_start, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_seg", ss_abcdefg_l, 7'h01);
    chk("rel_sel", ss_sel_l, 4'hE);

    // Load and scan
    do_load(16'h1A2F, 4'b0100);
    chk("load_pending", pending, 1'b1);
    chk("pre_boundary_seg", ss_abcdefg_l, 7'h01);
    wait_frame();
    chk("boundary_pending_clear", pending, 1'b0);
    scan_frame(7'h38, 7'h12, 7'h08, 7'h4F, 4'b0100, 7);

    // Leading-zero blanking
    blank_lz = 1'b1;
    do_load(16'h0070, 4'b0000);
    wait_frame();
    scan_frame(7'h01, 7'h0F, 7'h7F, 7'h7F, 4'b0000, 7);
    blank_lz = 1'b0;
    scan_frame(7'h01, 7'h0F, 7'h01, 7'h01, 4'b0000, 7);
    blank_lz = 1'b1;
    do_load(16'h0000, 4'b0000);
    wait_frame();
    scan_frame(7'h01, 7'h7F, 7'h7F, 7'h7F, 4'b0000, 7);

    // Two loads in one frame: last wins
    do_load(16'h1111, 4'b0000);
    chk("db_pending_1", pending, 1'b1);
    step(3);
    do_load(16'h2222, 4'b0000);
    chk("db_pending_2", pending, 1'b1);
    wait_frame();
    chk("db_old_digit3", ss_abcdefg_l, 7'h7F);
    scan_frame(7'h12, 7'h12, 7'h12, 7'h12, 4'b0000, 7);

    // Load exactly on the frame boundary
    step(63);
    chk("bnd_pending_before", pending, 1'b0);
    blank_lz = 1'b0;
    value    = 16'h0005;
    dp_in    = 4'b0001;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
    chk("bnd_frame_start", frame_start, 1'b1);
    chk("bnd_pending", pending, 1'b0);
    @(negedge clk);
    chk("bnd_pending_after", pending, 1'b0);
    chk("bnd_seg", ss_abcdefg_l, 7'h24);
    chk("bnd_sel", ss_sel_l, 4'hE);
    chk("bnd_dp", ss_dp_l, 1'b0);

    // PWM brightness
    brightness = 3'd0;
    wait_frame();
    scan_frame(7'h24, 7'h01, 7'h01, 7'h01, 4'b0001, 0);
    brightness = 3'd3;
    scan_frame(7'h24, 7'h01, 7'h01, 7'h01, 4'b0001, 3);
    brightness = 3'd7;

    // Mid-frame reset with a pending load
    step(33);
    do_load(16'h8888, 4'b1111);
    chk("mid_pending", pending, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", ss_sel_l, 4'hF);
    chk("mid_rst_seg", ss_abcdefg_l, 7'h7F);
    chk("mid_rst_dp", ss_dp_l, 1'b1);
    chk("mid_rst_pending", pending, 1'b0);
    chk("mid_rst_frame_start", frame_start, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    scan_frame(7'h01, 7'h01, 7'h01, 7'h01, 4'b0000, 7);
    chk("post_rst_pending", pending, 1'b0);
    scan_frame(7'h01, 7'h01, 7'h01, 7'h01, 4'b0000, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ss_scan_driver.md
# ss_scan_driver

Time-multiplexed driver for the board's 4-digit, common-anode seven-segment display. Sits directly downstream of the application logic in `top`. It captures a 16-bit hex value plus per-digit decimal points on a load strobe and drives `ss_abcdefg_l`, `ss_dp_l` and `ss_sel_l`. It adds frame-synchronous double buffering (no tearing), leading-zero blanking and 8-level PWM brightness.

## Interface
- `DIGIT_CYCLES`, default 50000: clk cycles each digit is selected (1 kHz/digit at 50 MHz); must be a multiple of 8, ≥ 8.
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low; one clock, no other reset.
- `load` in 1: one-cycle strobe; captures `value` and `dp_in` into the shadow register.
- `value` in 16: four hex nibbles; [3:0] is the rightmost digit (digit 0).
- `dp_in` in 4: decimal point per digit, 1 = lit; bit i belongs to digit i.
- `blank_lz` in 1: 1 = leading-zero blanking enabled; sampled every cycle.
- `brightness` in 3: 0 = dimmest (1/8 on-time), 7 = full on; sampled every cycle.
- `pending` out 1: shadow holds a load not yet shown.
- `frame_start` out 1: one-cycle pulse when digit 0 becomes selected.
- `ss_abcdefg_l` out 7: segments, active-low; bit 6 = a … bit 0 = g.
- `ss_dp_l` out 1: decimal point, active-low.
- `ss_sel_l` out 4: digit enables, active-low; bit i = digit i.

## Operation
- Counters:
  - `tick` runs 0..DIGIT_CYCLES-1.
  - `digit` (2 bits) advances when `tick` wraps, sequencing 0→1→2→3→0.
  - Frame = 4·DIGIT_CYCLES cycles.
- Buffers:
  - Shadow {value,dp} is written on `load`; `pending` is set.
  - Frame boundary = the cycle where `tick` wraps and `digit`=3. At the boundary, if `pending`, copy shadow to the active register and clear `pending`.
  - `load` coincident with the boundary: `value`/`dp_in` go straight to both shadow and active; `pending` ends 0.
  - `load` while `pending`: overwrites shadow (last load wins).
- Decode, active-low abcdefg:
  - 0=01, 1=4F, 2=12, 3=06, 4=4C, 5=24, 6=20, 7=0F
  - 8=00, 9=04, A=08, b=60, C=31, d=42, E=30, F=38
- Leading-zero blanking: when `blank_lz`=1, digit i (i=1..3) is blanked (segments 7F) if its nibble and all higher nibbles are 0. Digit 0 is never blanked. DP is unaffected by blanking.
- PWM: a digit period is split into 8 subslots of DIGIT_CYCLES/8 cycles each. In subslot s, `ss_sel_l` selects the current digit only if s ≤ `brightness`; otherwise it is F. Segment/DP outputs still follow the current digit.
- Exactly one `ss_sel_l` bit is low whenever any is low.

## Timing
- Reset values:
  - `ss_sel_l`=F, `ss_abcdefg_l`=7F, `ss_dp_l`=1, `pending`=0, `frame_start`=0.
  - Active/shadow registers=0; `tick`=0; `digit`=0.
- After reset release, the first active cycle displays digit 0.
- `frame_start` pulses on the first cycle of each digit-0 period, except the first after reset. It fires one cycle before outputs show digit 0.
- All display outputs are registered with a 1-cycle latency from counter state.
- `load` to display: new data appears on outputs 1 cycle after the next frame boundary. Worst case is 4·DIGIT_CYCLES+1 cycles.
- `pending` rises the cycle after `load` and falls the cycle after the boundary.
- `rst_n` asserted mid-frame: all outputs go to reset values immediately (async) and any pending load is discarded.

## Structure
- Shared package `ss_pkg`:
  - 16-entry hex→segment constant table.
  - `SEG_BLANK`=7'h7F and `SEL_NONE`=4'hF.
- Sub-module `ss_hex_decode`: combinational nibble → 7-bit segment pattern. It is reused by other display blocks.
- Counters, buffers, blanking and PWM live in `ss_scan_driver`.

## Test plan
All scenarios use DIGIT_CYCLES=16.
- **Reset:** hold `rst_n`=0 → sel=F, seg=7F, dp=1, pending=0. Release → first cycle shows digit 0 segments 01 with sel=E.
- **Load and scan:** `load` value=1A2F, dp_in=0100, brightness=7.
  - Before the first boundary: all digits show 01 (value 0).
  - From the next frame, over 64 cycles: sel E/D/B/7 show 38, 12, 08, 4F respectively, with dp_l=0 only while sel=B.
- **Blanking:** value=0070, blank_lz=1 → digit 3 and digit 2 show 7F; digit 1 shows 0F; digit 0 shows 01. With blank_lz=0 → digit 3 and digit 2 show 01. Value=0000 → only digit 0 is lit.
- **Double-buffer boundary:**
  - Two loads in one frame (1111 then 2222) → only 2222 is ever displayed.
  - `load` exactly on the boundary cycle → shown the following cycle, with `pending` never observed at 1.
- **PWM:** brightness=0 → sel low for 2 of every 16 cycles. brightness=3 → 8 of 16. Segment outputs are unchanged in both cases.
- **Mid-frame reset:** assert `rst_n` during digit 2 with pending=1 → outputs are immediately at reset values. After release, the display shows 0000 and pending=0.
